// File: rtl/pcm_cache_pkg.sv
// Shared definitions for the PCM ROM read cache.
//   LINE_BYTES / OFF_W : geometry of one cached DDRAM line (8 bytes, 3 offset bits)
//   state_t            : controller states
//   byte_sel()         : pick byte 'off' out of a 64-bit line (byte n = line[8n+:8])
package pcm_cache_pkg;

  localparam int LINE_BYTES = 8;
  localparam int OFF_W      = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HIT       = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    FILL      = 3'd4
  } state_t;

  function automatic logic [7:0] byte_sel(input logic [8*LINE_BYTES-1:0] line,
                                          input logic [OFF_W-1:0]        off);
    return line[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/pcm_rom_cache.sv
// Direct-mapped read cache between the PCM sample fetcher and DDRAM channel 1.
// Each request returns one byte; lines are 8 bytes, fetched whole from DDRAM.
//   clk_sys      : system clock
//   reset        : synchronous active-high reset, overrides a fetch in flight
//   flush        : level; clears all valid bits every cycle while high
//   rom_addr     : byte address, sampled with rom_read
//   rom_read     : one-cycle request strobe (ignored while busy)
//   rom_data     : returned byte, held after the rdy pulse
//   rom_data_rdy : one-cycle completion pulse
//   ddr_addr     : line-aligned fetch address, held from request to ready
//   ddr_req      : one-cycle fetch request pulse
//   ddr_data     : 64-bit line, byte n = ddr_data[8n+:8]
//   ddr_ready    : one-cycle fetch completion pulse (ignored outside MISS_WAIT)
//   busy         : high from accepted request through the rdy cycle
module pcm_rom_cache
  import pcm_cache_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int IDX_W  = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_read,
  output logic [7:0]        rom_data,
  output logic              rom_data_rdy,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_req,
  input  logic [63:0]       ddr_data,
  input  logic              ddr_ready,
  output logic              busy
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [ADDR_W-1:0]  ddr_addr_reg;
  logic [7:0]         rom_data_reg;
  logic               rdy_reg;
  logic               flush_seen_reg;

  logic [63:0]        line_data [LINES];
  logic [TAG_W-1:0]   line_tag  [LINES];
  logic [LINES-1:0]   line_valid;

  // Fields of the incoming request and of the latched request
  logic [IDX_W-1:0]   in_idx;
  logic [TAG_W-1:0]   in_tag;
  logic [OFF_W-1:0]   cur_off;
  logic [IDX_W-1:0]   cur_idx;
  logic [TAG_W-1:0]   cur_tag;

  assign in_idx  = rom_addr[IDX_W+OFF_W-1:OFF_W];
  assign in_tag  = rom_addr[ADDR_W-1:IDX_W+OFF_W];
  assign cur_off = addr_reg[OFF_W-1:0];
  assign cur_idx = addr_reg[IDX_W+OFF_W-1:OFF_W];
  assign cur_tag = addr_reg[ADDR_W-1:IDX_W+OFF_W];

  logic accept;
  logic lookup_hit;
  logic fill;

  // busy also covers the rdy cycle after a hit, so a strobe coincident
  // with rom_data_rdy is dropped like any other strobe while busy.
  assign busy       = (state_reg != IDLE) || rdy_reg;
  assign accept     = rom_read && !busy;
  // A held flush forces misses even though the valid bits clear only at the edge.
  assign lookup_hit = line_valid[in_idx] && !flush && (line_tag[in_idx] == in_tag);
  assign fill       = (state_reg == MISS_WAIT) && ddr_ready;

  always_comb begin
    state_next = state_reg;
    ddr_req    = 1'b0;
    case (state_reg)
      IDLE:      if (accept) state_next = lookup_hit ? HIT : MISS_REQ;
      HIT:       state_next = IDLE;
      MISS_REQ: begin
        ddr_req    = 1'b1;
        state_next = MISS_WAIT;
      end
      MISS_WAIT: if (ddr_ready) state_next = FILL;
      FILL:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      ddr_addr_reg   <= '0;
      rom_data_reg   <= 8'h00;
      rdy_reg        <= 1'b0;
      flush_seen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rdy_reg   <= 1'b0;

      if (state_reg == IDLE && accept) begin
        addr_reg <= rom_addr;
        if (!lookup_hit) ddr_addr_reg <= {rom_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end

      // Hit data comes from the cache array one cycle after lookup; miss data
      // is taken straight off the DDRAM bus so rdy follows ddr_ready by one cycle.
      if (state_reg == HIT) begin
        rdy_reg      <= 1'b1;
        rom_data_reg <= byte_sel(line_data[cur_idx], cur_off);
      end else if (fill) begin
        rdy_reg      <= 1'b1;
        rom_data_reg <= byte_sel(ddr_data, cur_off);
      end

      if ((state_reg == MISS_REQ || state_reg == MISS_WAIT) && flush)
        flush_seen_reg <= 1'b1;
      else if (state_reg == FILL)
        flush_seen_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      logic [63:0]      data_reg;
      logic [TAG_W-1:0] tag_reg;
      logic             valid_reg;
      logic             sel;

      assign sel = fill && (cur_idx == IDX_W'(gi));

      always_ff @(posedge clk_sys) begin
        if (sel) begin
          data_reg <= ddr_data;
          tag_reg  <= cur_tag;
        end
      end

      // A line fetched while a flush was seen may hold pre-reload ROM data,
      // so it is written but left invalid.
      always_ff @(posedge clk_sys) begin
        if (reset || flush)
          valid_reg <= 1'b0;
        else if (sel && !flush_seen_reg)
          valid_reg <= 1'b1;
      end

      assign line_data[gi]  = data_reg;
      assign line_tag[gi]   = tag_reg;
      assign line_valid[gi] = valid_reg;
    end
  endgenerate

  assign rom_data     = rom_data_reg;
  assign rom_data_rdy = rdy_reg;
  assign ddr_addr     = ddr_addr_reg;

endmodule

// File: tb/tb_pcm_rom_cache.sv
// Directed bench for pcm_rom_cache: hits, misses, conflicts, flush, protocol
// violations and reset during a fetch. Outputs are sampled on the falling edge.
module tb_pcm_rom_cache;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        flush;
  logic [17:0] rom_addr;
  logic        rom_read;
  logic [7:0]  rom_data;
  logic        rom_data_rdy;
  logic [17:0] ddr_addr;
  logic        ddr_req;
  logic [63:0] ddr_data;
  logic        ddr_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  pcm_rom_cache #(.ADDR_W(18), .IDX_W(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .flush        (flush),
    .rom_addr     (rom_addr),
    .rom_read     (rom_read),
    .rom_data     (rom_data),
    .rom_data_rdy (rom_data_rdy),
    .ddr_addr     (ddr_addr),
    .ddr_req      (ddr_req),
    .ddr_data     (ddr_data),
    .ddr_ready    (ddr_ready),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Idle-state outputs: no pulses, not busy.
  task automatic check_quiet(input string tag);
    check({tag, " rdy"},  rom_data_rdy, 1'b0);
    check({tag, " req"},  ddr_req,      1'b0);
    check({tag, " busy"}, busy,         1'b0);
  endtask

  // Strobe at a falling edge; rdy is expected on the second falling edge after it.
  task automatic read_hit(input logic [17:0] a, input logic [7:0] exp, input string tag);
    rom_addr = a; rom_read = 1'b1;
    @(negedge clk_sys); rom_read = 1'b0;
    check({tag, " hit req"},  ddr_req,      1'b0);
    check({tag, " hit rdy0"}, rom_data_rdy, 1'b0);
    check({tag, " hit busy"}, busy,         1'b1);
    @(negedge clk_sys);
    check({tag, " hit rdy"},  rom_data_rdy, 1'b1);
    check({tag, " hit data"}, rom_data,     exp);
    @(negedge clk_sys);
    check_quiet({tag, " hit end"});
    check({tag, " hit hold"}, rom_data, exp);
    $display("read  0x%05h hit  -> 0x%02h", a, rom_data);
  endtask

  // Miss: ddr_req one cycle after the strobe, ddr_ready 'delay' cycles after
  // ddr_req, rdy one cycle after ddr_ready. flush_at pulses flush in that
  // wait cycle; hammer keeps rom_read high (with a different address) throughout.
  task automatic read_miss(input logic [17:0] a, input logic [63:0] line,
                           input logic [7:0] exp, input int delay,
                           input int flush_at, input bit hammer, input string tag);
    logic [17:0] line_addr;
    line_addr = a & 18'h3fff8;
    rom_addr = a; rom_read = 1'b1;
    @(negedge clk_sys);
    rom_read = hammer;
    if (hammer) rom_addr = 18'h00010;
    check({tag, " miss req"},   ddr_req,      1'b1);
    check({tag, " miss daddr"}, ddr_addr,     line_addr);
    check({tag, " miss rdy0"},  rom_data_rdy, 1'b0);
    check({tag, " miss busy"},  busy,         1'b1);
    for (int i = 1; i <= delay; i++) begin
      flush = (i == flush_at);
      @(negedge clk_sys);
      check({tag, " wait req"},   ddr_req,      1'b0);
      check({tag, " wait rdy"},   rom_data_rdy, 1'b0);
      check({tag, " wait daddr"}, ddr_addr,     line_addr);
      if (i == delay) begin ddr_ready = 1'b1; ddr_data = line; end
    end
    flush = 1'b0;
    @(negedge clk_sys);
    ddr_ready = 1'b0; ddr_data = 64'h0;
    check({tag, " fill rdy"},  rom_data_rdy, 1'b1);
    check({tag, " fill data"}, rom_data,     exp);
    check({tag, " fill busy"}, busy,         1'b1);
    @(negedge clk_sys);
    rom_read = 1'b0;
    check_quiet({tag, " fill end"});
    $display("read  0x%05h miss -> 0x%02h (ddr_addr 0x%05h)", a, rom_data, line_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; rom_addr = '0; rom_read = 1'b0;
    ddr_data = '0; ddr_ready = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    // 1: reset state
    check("reset data",  rom_data, 8'h00);
    check("reset daddr", ddr_addr, 18'h0);
    check_quiet("reset");
    $display("reset released");

    // 1: cold miss, ready 5 cycles after req
    read_miss(18'h00010, 64'h8877665544332211, 8'h11, 5, 0, 1'b0, "t1");
    // 2: same line hits
    read_hit(18'h00013, 8'h44, "t2a");
    read_hit(18'h00017, 8'h88, "t2b");

    // 3: conflict on index 2, then back
    read_miss(18'h00030, 64'hA7A6A5A4A3A2A1A0, 8'hA0, 3, 0, 1'b0, "t3a");
    read_hit (18'h00035, 8'hA5, "t3b");
    read_miss(18'h00012, 64'h8877665544332211, 8'h33, 2, 0, 1'b0, "t3c");
    read_miss(18'h0000F, 64'hF7F6F5F4F3F2F1F0, 8'hF7, 1, 0, 1'b0, "t3d");
    read_hit (18'h00016, 8'h77, "t3e");
    read_hit (18'h00008, 8'hF0, "t3f");

    // 4: flush during MISS_WAIT returns the byte but leaves the line invalid
    read_miss(18'h00100, 64'h0123456789ABCDEF, 8'hEF, 5, 2, 1'b0, "t4a");
    read_miss(18'h00101, 64'h0123456789ABCDEF, 8'hCD, 1, 0, 1'b0, "t4b");
    read_hit (18'h00102, 8'hAB, "t4c");
    flush = 1'b1; @(negedge clk_sys); flush = 1'b0;
    read_miss(18'h00102, 64'h0123456789ABCDEF, 8'hAB, 2, 0, 1'b0, "t4d");

    // 5: strobes while busy and in the rdy cycle are ignored
    rom_addr = 18'h00104; rom_read = 1'b1;
    @(negedge clk_sys);
    rom_addr = 18'h00030;
    check("t5 busy strobe req", ddr_req, 1'b0);
    @(negedge clk_sys);
    check("t5 rdy", rom_data_rdy, 1'b1);
    check("t5 data", rom_data, 8'h67);
    @(negedge clk_sys);
    rom_read = 1'b0;
    check_quiet("t5 after rdy strobe");
    $display("read  0x00104 hit  with extra strobes -> 0x%02h", rom_data);
    read_miss(18'h00200, 64'h1122334455667788, 8'h88, 4, 0, 1'b1, "t5b");
    ddr_ready = 1'b1; ddr_data = 64'hDEADBEEFDEADBEEF;
    @(negedge clk_sys);
    ddr_ready = 1'b0; ddr_data = '0;
    check_quiet("t5 stray ready");
    @(negedge clk_sys);
    check_quiet("t5 stray ready+1");
    check("t5 stray hold", rom_data, 8'h88);
    $display("stray ddr_ready in IDLE");
    read_hit(18'h00207, 8'h11, "t5c");

    // 6: reset during MISS_WAIT, late ddr_ready dropped, cache emptied
    rom_addr = 18'h00040; rom_read = 1'b1;
    @(negedge clk_sys);
    rom_read = 1'b0;
    check("t6 req", ddr_req, 1'b1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("t6 rst daddr", ddr_addr, 18'h0);
    check("t6 rst data",  rom_data, 8'h00);
    check_quiet("t6 rst");
    ddr_ready = 1'b1; ddr_data = 64'h5555555555555555;
    @(negedge clk_sys);
    ddr_ready = 1'b0; ddr_data = '0;
    check("t6 late data", rom_data, 8'h00);
    check_quiet("t6 late ready");
    @(negedge clk_sys);
    check_quiet("t6 late ready+1");
    $display("reset during MISS_WAIT");
    read_miss(18'h00012, 64'h8877665544332211, 8'h33, 2, 0, 1'b0, "t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
